// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Round-robin arbiter/sequencer for the shared multi-cycle ALU.
//            Grants one of two requesters, runs the four-phase ready/complete
//            handshake, returns the result on the requester's own port with a
//            one-cycle done pulse, filters illegal codes and guards the
//            handshake with a watchdog.
// Revision : 1.0  initial release
// ============================================================================
module alu_arbiter #(
  parameter int WORD_SIZE = 16,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [WORD_SIZE-1:0] a0,
  input  logic [WORD_SIZE-1:0] b0,
  input  logic [WORD_SIZE-1:0] a1,
  input  logic [WORD_SIZE-1:0] b1,
  input  logic [3:0]           code0,
  input  logic [3:0]           code1,
  output logic                 done0,
  output logic                 done1,
  output logic [WORD_SIZE-1:0] result0,
  output logic [WORD_SIZE-1:0] result1,
  output logic                 ill,
  output logic                 fault,
  output logic                 busy,
  output logic [WORD_SIZE-1:0] alu_a,
  output logic [WORD_SIZE-1:0] alu_b,
  output logic [3:0]           alu_code,
  output logic                 alu_ready,
  input  logic                 alu_complete,
  input  logic [WORD_SIZE-1:0] alu_c
);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_ISSUE   = 3'd1;
  localparam logic [2:0] c_WAIT_HI = 3'd2;
  localparam logic [2:0] c_DONE    = 3'd3;
  localparam logic [2:0] c_WAIT_LO = 3'd4;

  // Last counter value before the watchdog fires: gives exactly TIMEOUT cycles.
  localparam logic [7:0] c_WD_LAST = 8'(TIMEOUT - 1);
  localparam logic [3:0] c_MAX_CODE = 4'd10;

  logic [2:0]           r_state;
  logic [2:0]           w_next;
  logic                 r_last_grant;
  logic [7:0]           r_wd_cnt;
  logic                 r_ill_op;
  logic                 r_fault;
  logic                 r_alu_ready;
  logic [WORD_SIZE-1:0] r_alu_a;
  logic [WORD_SIZE-1:0] r_alu_b;
  logic [3:0]           r_alu_code;
  logic [WORD_SIZE-1:0] r_result0;
  logic [WORD_SIZE-1:0] r_result1;

  logic                 w_gnt_valid;
  logic                 w_gnt_port;
  logic [3:0]           w_gnt_code;
  logic                 w_gnt_ill;
  logic                 w_wd_expired;
  logic                 w_grant;

  // Round-robin winner selection; on a tie the port not served last wins.
  always_comb begin
    w_gnt_valid = req0 | req1;
    if (req0 && req1) begin
      w_gnt_port = ~r_last_grant;
    end else begin
      w_gnt_port = req1;
    end
    w_gnt_code   = w_gnt_port ? code1 : code0;
    w_gnt_ill    = (w_gnt_code > c_MAX_CODE);
    w_wd_expired = (r_wd_cnt == c_WD_LAST);
    w_grant      = (r_state == c_IDLE) && w_gnt_valid;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; complete takes priority over a simultaneous watchdog expiry.
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_gnt_valid) begin
          w_next = w_gnt_ill ? c_DONE : c_ISSUE;
        end
      end
      c_ISSUE:   w_next = c_WAIT_HI;
      c_WAIT_HI: begin
        if (alu_complete || w_wd_expired) begin
          w_next = c_DONE;
        end
      end
      c_DONE:    w_next = r_ill_op ? c_IDLE : c_WAIT_LO;
      c_WAIT_LO: begin
        if (!alu_complete || w_wd_expired) begin
          w_next = c_IDLE;
        end
      end
      default:   w_next = c_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    done0 = (r_state == c_DONE) && !r_last_grant;
    done1 = (r_state == c_DONE) &&  r_last_grant;
    ill   = (r_state == c_DONE) &&  r_ill_op;
    busy  = (r_state != c_IDLE);
  end

  // Grant bookkeeping and operand registers loaded when a port is granted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
      r_ill_op     <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_code   <= '0;
    end else if (w_grant) begin
      r_last_grant <= w_gnt_port;
      r_ill_op     <= w_gnt_ill;
      r_alu_a      <= w_gnt_port ? a1 : a0;
      r_alu_b      <= w_gnt_port ? b1 : b0;
      r_alu_code   <= w_gnt_code;
    end
  end

  // Handshake request is registered from the next state so it is glitch-free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_alu_ready <= 1'b0;
    end else begin
      r_alu_ready <= (w_next == c_WAIT_HI);
    end
  end

  // Watchdog counter: clears on entry to each wait state, counts while staying.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wd_cnt <= '0;
    end else if (((r_state == c_WAIT_HI) || (r_state == c_WAIT_LO)) && (w_next == r_state)) begin
      r_wd_cnt <= r_wd_cnt + 8'd1;
    end else begin
      r_wd_cnt <= '0;
    end
  end

  // Sticky fault on watchdog expiry in either handshake phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fault <= 1'b0;
    end else if (w_wd_expired &&
                 (((r_state == c_WAIT_HI) && !alu_complete) ||
                  ((r_state == c_WAIT_LO) &&  alu_complete))) begin
      r_fault <= 1'b1;
    end
  end

  // Per-port result registers; only the granted port's register is written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_result0 <= '0;
      r_result1 <= '0;
    end else if (w_grant && w_gnt_ill) begin
      if (w_gnt_port) r_result1 <= '0;
      else            r_result0 <= '0;
    end else if ((r_state == c_WAIT_HI) && (alu_complete || w_wd_expired)) begin
      if (r_last_grant) r_result1 <= alu_complete ? alu_c : '0;
      else              r_result0 <= alu_complete ? alu_c : '0;
    end
  end

  assign result0   = r_result0;
  assign result1   = r_result1;
  assign fault     = r_fault;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_code  = r_alu_code;
  assign alu_ready = r_alu_ready;

endmodule
`default_nettype wire
